// File: rtl/approx_adder_error_monitor.sv
// Error-characterisation monitor for approximate adders: recomputes the exact sum and
// accumulates error count, saturating error-distance sum and maximum over a sample window.
module approx_adder_error_monitor #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16,
  parameter int ACC_W = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [CNT_W-1:0]   num_samples_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [WIDTH-1:0]   add1_i,
  input  logic [WIDTH-1:0]   add2_i,
  input  logic [WIDTH:0]     approx_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [CNT_W-1:0]   err_count_o,
  output logic [ACC_W-1:0]   err_sum_o,
  output logic [WIDTH:0]     err_max_o
);

  localparam int EXT_W = ((ACC_W > WIDTH + 1) ? ACC_W : WIDTH + 1) + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   accepted_q, num_q;
  logic               vld_p0;
  logic [WIDTH-1:0]   add1_p0, add2_p0;
  logic [WIDTH:0]     approx_p0;
  logic [CNT_W-1:0]   err_count_q;
  logic [ACC_W-1:0]   err_sum_q;
  logic [WIDTH:0]     err_max_q;
  logic               accept, start_ok;
  logic [WIDTH:0]     exact, ed;

  function automatic logic [WIDTH:0] abs_err(input logic [WIDTH:0] a, input logic [WIDTH:0] b);
    logic signed [WIDTH+1:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    if (d < 0) d = -d;
    return d[WIDTH:0];
  endfunction

  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] acc, input logic [WIDTH:0] inc);
    logic [EXT_W-1:0] s;
    s = EXT_W'(acc) + EXT_W'(inc);
    if (s[EXT_W-1:ACC_W] != '0) return '1;
    return s[ACC_W-1:0];
  endfunction

  assign start_ok = start_i && (state_q != ST_RUN);
  assign accept   = valid_i && ready_o;

  always_comb begin
    state_d = state_q;
    ready_o = 1'b0;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        done_o = (state_q == ST_DONE);
        if (start_i) state_d = (num_samples_i == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        busy_o  = 1'b1;
        ready_o = (accepted_q < num_q);
        // Once the window is fully accepted, the last sample retires on this same edge.
        if (accepted_q == num_q) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      accepted_q <= '0;
      num_q      <= '0;
      vld_p0     <= 1'b0;
    end else begin
      state_q <= state_d;
      vld_p0  <= accept;
      if (start_ok) begin
        accepted_q <= '0;
        num_q      <= num_samples_i;
      end else if (accept) begin
        accepted_q <= accepted_q + CNT_W'(1);
      end
    end
  end

  // Stage 0: capture operands and adder result
  always_ff @(posedge clk_i) begin
    if (accept) begin
      add1_p0   <= add1_i;
      add2_p0   <= add2_i;
      approx_p0 <= approx_i;
    end
  end

  // Stage 1: exact sum, error distance, statistics update
  assign exact = {1'b0, add1_p0} + {1'b0, add2_p0};
  assign ed    = abs_err(approx_p0, exact);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_count_q <= '0;
      err_sum_q   <= '0;
      err_max_q   <= '0;
    end else if (start_ok) begin
      err_count_q <= '0;
      err_sum_q   <= '0;
      err_max_q   <= '0;
    end else if (vld_p0) begin
      if (ed != '0) err_count_q <= err_count_q + CNT_W'(1);
      err_sum_q <= sat_add(err_sum_q, ed);
      if (ed > err_max_q) err_max_q <= ed;
    end
  end

  assign err_count_o = err_count_q;
  assign err_sum_o   = err_sum_q;
  assign err_max_o   = err_max_q;

endmodule

// File: tb/tb_approx_adder_error_monitor.sv
// Directed bench for approx_adder_error_monitor; a second instance with an 8-bit
// accumulator exercises error-sum saturation.
module tb_approx_adder_error_monitor;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic [15:0] num_samples_i;
  logic        valid_i;
  logic [15:0] add1_i, add2_i;
  logic [16:0] approx_i;

  logic        ready_o, busy_o, done_o;
  logic [15:0] err_count_o;
  logic [31:0] err_sum_o;
  logic [16:0] err_max_o;

  logic        ready8, busy8, done8;
  logic [15:0] count8;
  logic [7:0]  sum8;
  logic [16:0] max8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  approx_adder_error_monitor #(.WIDTH(16), .CNT_W(16), .ACC_W(32)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .num_samples_i(num_samples_i),
    .valid_i(valid_i), .ready_o(ready_o), .add1_i(add1_i), .add2_i(add2_i),
    .approx_i(approx_i), .busy_o(busy_o), .done_o(done_o),
    .err_count_o(err_count_o), .err_sum_o(err_sum_o), .err_max_o(err_max_o)
  );

  approx_adder_error_monitor #(.WIDTH(16), .CNT_W(16), .ACC_W(8)) dut8 (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .num_samples_i(num_samples_i),
    .valid_i(valid_i), .ready_o(ready8), .add1_i(add1_i), .add2_i(add2_i),
    .approx_i(approx_i), .busy_o(busy8), .done_o(done8),
    .err_count_o(count8), .err_sum_o(sum8), .err_max_o(max8)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] n);
    start_i       = 1'b1;
    num_samples_i = n;
    step();
    start_i = 1'b0;
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic [16:0] r);
    valid_i  = 1'b1;
    add1_i   = a;
    add2_i   = b;
    approx_i = r;
    step();
    valid_i = 1'b0;
  endtask

  task automatic check_stats(input string tag, input logic [31:0] c,
                             input logic [31:0] s, input logic [31:0] m);
    check_val({tag, "_count"}, err_count_o, c);
    check_val({tag, "_sum"},   err_sum_o,   s);
    check_val({tag, "_max"},   err_max_o,   m);
  endtask

  initial begin
    rst_ni = 1'b0; start_i = 1'b0; num_samples_i = '0; valid_i = 1'b0;
    add1_i = '0; add2_i = '0; approx_i = '0;
    step(); step();
    check_val("rst_ready", ready_o, 0);
    check_val("rst_busy",  busy_o,  0);
    check_val("rst_done",  done_o,  0);
    check_stats("rst", 0, 0, 0);
    rst_ni = 1'b1;
    step();

    // 1) four back-to-back samples, each one too large by 1
    do_start(16'd4);
    check_val("t1_busy",  busy_o,  1);
    check_val("t1_ready", ready_o, 1);
    drive(16'd10, 16'd5, 17'd16);
    drive(16'd20, 16'd5, 17'd26);
    drive(16'd30, 16'd5, 17'd36);
    drive(16'd40, 16'd5, 17'd46);
    check_val("t1_ready_after_last", ready_o, 0);
    check_val("t1_done_early",       done_o,  0);
    step();
    check_val("t1_done", done_o, 1);
    check_val("t1_busy_done", busy_o, 0);
    check_stats("t1", 4, 4, 1);
    step(); step();
    check_stats("t1_hold", 4, 4, 1);

    // 2) full-scale operands: exact sum is 17'h1FFFE
    do_start(16'd1);
    drive(16'hFFFF, 16'hFFFF, 17'h1FFFF);
    step();
    check_val("t2_done", done_o, 1);
    check_stats("t2", 1, 1, 1);

    // 3) exact, exact-5, exact+300 with gaps
    do_start(16'd3);
    drive(16'd1000, 16'd2000, 17'd3000);
    step();
    drive(16'd10, 16'd20, 17'd25);
    step();
    check_val("t3_ready_mid", ready_o, 1);
    drive(16'd100, 16'd200, 17'd600);
    check_val("t3_ready_low", ready_o, 0);
    drive(16'd1, 16'd1, 17'd999);   // dropped: ready_o is low
    step();
    check_val("t3_done", done_o, 1);
    check_stats("t3", 2, 305, 300);
    check_val("t3_sum8_sat", sum8, 8'hFF);

    // 4) three samples of distance 200 each
    do_start(16'd3);
    drive(16'd100, 16'd0, 17'd300);
    drive(16'd100, 16'd0, 17'd300);
    drive(16'd100, 16'd0, 17'd300);
    step();
    check_val("t4_done8",  done8,  1);
    check_val("t4_sum8",   sum8,   8'hFF);
    check_val("t4_count8", count8, 3);
    check_val("t4_max8",   max8,   200);
    check_val("t4_sum32",  err_sum_o, 600);

    // 5) empty window, then a new window clears stats
    do_start(16'd0);
    check_val("t5_done",  done_o,  1);
    check_val("t5_ready", ready_o, 0);
    check_val("t5_busy",  busy_o,  0);
    check_stats("t5", 0, 0, 0);
    do_start(16'd2);
    check_val("t5_busy_run", busy_o, 1);
    check_val("t5_ready_run", ready_o, 1);
    drive(16'd7, 16'd8, 17'd12);
    start_i = 1'b1; num_samples_i = 16'd9;   // ignored during RUN
    drive(16'd7, 16'd8, 17'd19);
    start_i = 1'b0;
    step();
    check_val("t5_done_after_2", done_o, 1);
    check_stats("t5_run", 2, 7, 4);

    // 6) asynchronous reset in the middle of a window
    do_start(16'd4);
    drive(16'd50, 16'd50, 17'd109);
    step();
    check_val("t6_pre_count", err_count_o, 1);
    rst_ni = 1'b0;
    #2;
    check_val("t6_rst_busy",  busy_o,  0);
    check_val("t6_rst_ready", ready_o, 0);
    check_stats("t6_rst", 0, 0, 0);
    step();
    rst_ni = 1'b1;
    step();
    check_val("t6_idle_done", done_o, 0);
    do_start(16'd1);
    drive(16'd3, 16'd4, 17'd4);
    step();
    check_val("t6_rerun_done", done_o, 1);
    check_stats("t6_rerun", 1, 3, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
